// File: rtl/register_scoreboard.sv
// Register file with per-register pending-write counters for in-order issue.
// Tracks outstanding writebacks, flags read hazards and optionally forwards writeback data.
module register_scoreboard #(
  parameter int LEN_REG   = 32,
  parameter int LEN_REGNO = 4,
  parameter int LEN_PEND  = 2,
  parameter int BYPASS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LEN_REGNO-1:0] rd_regno_i,
  input  logic [LEN_REGNO-1:0] rs_regno_i,
  input  logic                 rd_use_i,
  input  logic                 rs_use_i,
  output logic [LEN_REG-1:0]   rd_data_o,
  output logic [LEN_REG-1:0]   rs_data_o,
  output logic                 rd_busy_o,
  output logic                 rs_busy_o,
  output logic                 hazard_o,
  input  logic                 rsv_i,
  input  logic [LEN_REGNO-1:0] rsv_regno_i,
  output logic                 rsv_ok_o,
  input  logic                 wb_i,
  input  logic [LEN_REGNO-1:0] wb_regno_i,
  input  logic [LEN_REG-1:0]   wb_data_i,
  output logic                 pend_any_o,
  output logic                 err_o
);

  localparam int NREG = 2 ** LEN_REGNO;
  localparam logic [LEN_PEND-1:0] PMAX = {LEN_PEND{1'b1}};
  localparam logic [LEN_PEND-1:0] PONE = LEN_PEND'(1);

  logic [LEN_REG-1:0]  data_arr [NREG];
  logic [LEN_PEND-1:0] pend_arr [NREG];
  logic [NREG-1:0]     pend_nz;

  logic rd_wb_hit, rs_wb_hit, rsv_wb_hit;
  logic err_reg, err_next;

  assign rd_wb_hit  = wb_i & (wb_regno_i == rd_regno_i);
  assign rs_wb_hit  = wb_i & (wb_regno_i == rs_regno_i);
  assign rsv_wb_hit = wb_i & (wb_regno_i == rsv_regno_i);

  assign rd_data_o = ((BYPASS != 0) && rd_wb_hit) ? wb_data_i : data_arr[rd_regno_i];
  assign rs_data_o = ((BYPASS != 0) && rs_wb_hit) ? wb_data_i : data_arr[rs_regno_i];

  // The final outstanding write retiring this cycle is forwarded, so it no longer blocks.
  assign rd_busy_o = (pend_arr[rd_regno_i] != '0) &
                     !((BYPASS != 0) && rd_wb_hit && (pend_arr[rd_regno_i] == PONE));
  assign rs_busy_o = (pend_arr[rs_regno_i] != '0) &
                     !((BYPASS != 0) && rs_wb_hit && (pend_arr[rs_regno_i] == PONE));

  assign hazard_o = (rd_use_i & rd_busy_o) | (rs_use_i & rs_busy_o);

  // A full counter can still accept when a same-register writeback frees a slot.
  assign rsv_ok_o = rsv_i & ((pend_arr[rsv_regno_i] != PMAX) | rsv_wb_hit);

  assign pend_any_o = |pend_nz;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    logic [LEN_REG-1:0]  data_reg;
    logic [LEN_PEND-1:0] pend_reg, pend_next;
    logic                wb_hit, inc;

    assign wb_hit = wb_i & (wb_regno_i == LEN_REGNO'(gi));
    assign inc    = rsv_ok_o & (rsv_regno_i == LEN_REGNO'(gi));

    always_comb begin
      pend_next = pend_reg;
      if (inc && !wb_hit) begin
        if (pend_reg != PMAX) pend_next = pend_reg + PONE;
      end else if (wb_hit && !inc && (pend_reg != '0)) begin
        pend_next = pend_reg - PONE;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_reg <= '0;
        pend_reg <= '0;
      end else begin
        pend_reg <= pend_next;
        if (wb_hit) data_reg <= wb_data_i;
      end
    end

    assign data_arr[gi] = data_reg;
    assign pend_arr[gi] = pend_reg;
    assign pend_nz[gi]  = |pend_reg;
  end

  // Writeback with nothing outstanding (and not matched by a same-cycle reservation).
  assign err_next = wb_i & (pend_arr[wb_regno_i] == '0) & !(rsv_ok_o & rsv_wb_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_reg <= 1'b0;
    else     err_reg <= err_next;
  end

  assign err_o = err_reg;

endmodule

// File: tb/tb_register_scoreboard.sv
// Scoreboard bench for register_scoreboard: one forwarding and one non-forwarding instance
// share stimulus; expectations are queued by the stimulus and checked by a negedge monitor.
module tb_register_scoreboard;

  localparam int F_RD_DATA = 0, F_RS_DATA = 1, F_RD_BUSY = 2, F_RS_BUSY = 3;
  localparam int F_HAZ = 4, F_RSV_OK = 5, F_PEND_ANY = 6, F_ERR = 7;

  typedef struct {
    string       nm;
    int          fld;
    logic [31:0] val;
    bit          inst;  // 1: BYPASS=1 instance, 0: BYPASS=0 instance
  } exp_t;

  logic        clk, rst;
  logic [3:0]  rd_regno, rs_regno, rsv_regno, wb_regno;
  logic        rd_use, rs_use, rsv, wb;
  logic [31:0] wb_data;

  logic [31:0] b_rd_data, b_rs_data, n_rd_data, n_rs_data;
  logic        b_rd_busy, b_rs_busy, b_haz, b_rsv_ok, b_pend_any, b_err;
  logic        n_rd_busy, n_rs_busy, n_haz, n_rsv_ok, n_pend_any, n_err;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  register_scoreboard #(.BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst),
    .rd_regno_i(rd_regno), .rs_regno_i(rs_regno), .rd_use_i(rd_use), .rs_use_i(rs_use),
    .rd_data_o(b_rd_data), .rs_data_o(b_rs_data), .rd_busy_o(b_rd_busy), .rs_busy_o(b_rs_busy),
    .hazard_o(b_haz), .rsv_i(rsv), .rsv_regno_i(rsv_regno), .rsv_ok_o(b_rsv_ok),
    .wb_i(wb), .wb_regno_i(wb_regno), .wb_data_i(wb_data),
    .pend_any_o(b_pend_any), .err_o(b_err)
  );

  register_scoreboard #(.BYPASS(0)) dut_nob (
    .clk(clk), .rst(rst),
    .rd_regno_i(rd_regno), .rs_regno_i(rs_regno), .rd_use_i(rd_use), .rs_use_i(rs_use),
    .rd_data_o(n_rd_data), .rs_data_o(n_rs_data), .rd_busy_o(n_rd_busy), .rs_busy_o(n_rs_busy),
    .hazard_o(n_haz), .rsv_i(rsv), .rsv_regno_i(rsv_regno), .rsv_ok_o(n_rsv_ok),
    .wb_i(wb), .wb_regno_i(wb_regno), .wb_data_i(wb_data),
    .pend_any_o(n_pend_any), .err_o(n_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] actual(int fld, bit inst);
    case (fld)
      F_RD_DATA:  return inst ? b_rd_data : n_rd_data;
      F_RS_DATA:  return inst ? b_rs_data : n_rs_data;
      F_RD_BUSY:  return {31'd0, inst ? b_rd_busy : n_rd_busy};
      F_RS_BUSY:  return {31'd0, inst ? b_rs_busy : n_rs_busy};
      F_HAZ:      return {31'd0, inst ? b_haz : n_haz};
      F_RSV_OK:   return {31'd0, inst ? b_rsv_ok : n_rsv_ok};
      F_PEND_ANY: return {31'd0, inst ? b_pend_any : n_pend_any};
      default:    return {31'd0, inst ? b_err : n_err};
    endcase
  endfunction

  // Monitor: outputs settle by mid-cycle; drain every expectation queued for this cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e   = q.pop_front();
      act = actual(e.fld, e.inst);
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s (bypass=%0d): got 0x%08h expected 0x%08h", e.nm, e.inst, act, e.val);
      end else begin
        $display("ok   %s (bypass=%0d): 0x%08h", e.nm, e.inst, act);
      end
    end
  end

  task automatic chk(string nm, int fld, logic [31:0] val, bit inst = 1'b1);
    exp_t e;
    e.nm = nm; e.fld = fld; e.val = val; e.inst = inst;
    q.push_back(e);
  endtask

  task automatic idle();
    rd_regno = '0; rs_regno = '0; rd_use = 1'b0; rs_use = 1'b0;
    rsv = 1'b0; rsv_regno = '0; wb = 1'b0; wb_regno = '0; wb_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_pend_any", F_PEND_ANY, 0);
    chk("rst_held_err", F_ERR, 0);
    tick();

    // Post-reset idle state
    rst = 1'b0; idle();
    rd_use = 1'b1; rs_use = 1'b1;
    chk("reset_rd_data", F_RD_DATA, 0);
    chk("reset_rs_data", F_RS_DATA, 0);
    chk("reset_rd_busy", F_RD_BUSY, 0);
    chk("reset_hazard", F_HAZ, 0);
    chk("reset_rsv_ok", F_RSV_OK, 0);
    chk("reset_pend_any", F_PEND_ANY, 0);
    tick();

    // Reserve 3, observe hazard, retire with forwarding
    idle(); rsv = 1'b1; rsv_regno = 4'd3;
    chk("rsv3_ok", F_RSV_OK, 1);
    chk("rsv3_pend_any_before_edge", F_PEND_ANY, 0);
    tick();
    idle(); rd_regno = 4'd3; rd_use = 1'b1; rs_regno = 4'd3;
    chk("r3_rd_busy", F_RD_BUSY, 1);
    chk("r3_rs_busy_same_reg", F_RS_BUSY, 1);
    chk("r3_hazard", F_HAZ, 1);
    chk("r3_pend_any", F_PEND_ANY, 1);
    tick();
    idle(); rd_regno = 4'd3; rd_use = 1'b1; rs_regno = 4'd3;
    wb = 1'b1; wb_regno = 4'd3; wb_data = 32'hDEADBEEF;
    chk("wb3_fwd_rd_data", F_RD_DATA, 32'hDEADBEEF);
    chk("wb3_fwd_rs_data", F_RS_DATA, 32'hDEADBEEF);
    chk("wb3_fwd_rd_busy", F_RD_BUSY, 0);
    chk("wb3_fwd_hazard", F_HAZ, 0);
    chk("wb3_nofwd_rd_data", F_RD_DATA, 0, 1'b0);
    chk("wb3_nofwd_rd_busy", F_RD_BUSY, 1, 1'b0);
    tick();
    idle(); rd_regno = 4'd3;
    chk("after_wb3_pend_any", F_PEND_ANY, 0);
    chk("after_wb3_err", F_ERR, 0);
    chk("after_wb3_data", F_RD_DATA, 32'hDEADBEEF);
    tick();

    // Saturate reg 5 at 3 outstanding writes
    for (int i = 0; i < 3; i++) begin
      idle(); rsv = 1'b1; rsv_regno = 4'd5;
      chk($sformatf("rsv5_%0d_ok", i), F_RSV_OK, 1);
      tick();
    end
    idle(); rsv = 1'b1; rsv_regno = 4'd5;
    chk("rsv5_full_reject", F_RSV_OK, 0);
    chk("rsv5_full_reject_nofwd", F_RSV_OK, 0, 1'b0);
    tick();
    idle(); rsv = 1'b1; rsv_regno = 4'd5; wb = 1'b1; wb_regno = 4'd5; wb_data = 32'h50;
    chk("rsv5_full_with_wb_ok", F_RSV_OK, 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      idle(); wb = 1'b1; wb_regno = 4'd5; wb_data = 32'h51 + i;
      tick();
    end
    idle(); rd_regno = 4'd5;
    chk("r5_one_left_busy", F_RD_BUSY, 1);
    chk("r5_one_left_pend_any", F_PEND_ANY, 1);
    chk("r5_no_underflow_err", F_ERR, 0);
    tick();
    idle(); rd_regno = 4'd5; wb = 1'b1; wb_regno = 4'd5; wb_data = 32'h53;
    chk("r5_last_wb_busy_fwd", F_RD_BUSY, 0);
    chk("r5_last_wb_busy_nofwd", F_RD_BUSY, 1, 1'b0);
    tick();
    idle(); rd_regno = 4'd5;
    chk("r5_drained_pend_any", F_PEND_ANY, 0);
    chk("r5_drained_err", F_ERR, 0);
    chk("r5_final_data", F_RD_DATA, 32'h53);
    tick();

    // Underflow writeback to reg 7
    idle(); wb = 1'b1; wb_regno = 4'd7; wb_data = 32'h12;
    chk("wb7_err_not_yet", F_ERR, 0);
    tick();
    idle(); rd_regno = 4'd7;
    chk("wb7_err_pulse", F_ERR, 1);
    chk("wb7_data", F_RD_DATA, 32'h12);
    chk("wb7_pend_any", F_PEND_ANY, 0);
    tick();
    idle();
    chk("wb7_err_cleared", F_ERR, 0);
    tick();

    // Non-forwarding timing on reg 2
    idle(); rsv = 1'b1; rsv_regno = 4'd2;
    tick();
    idle(); rd_regno = 4'd2; wb = 1'b1; wb_regno = 4'd2; wb_data = 32'h55;
    chk("nofwd_r2_busy", F_RD_BUSY, 1, 1'b0);
    chk("nofwd_r2_old_data", F_RD_DATA, 0, 1'b0);
    chk("fwd_r2_data", F_RD_DATA, 32'h55);
    tick();
    idle(); rd_regno = 4'd2;
    chk("nofwd_r2_new_data", F_RD_DATA, 32'h55, 1'b0);
    chk("nofwd_r2_busy_clear", F_RD_BUSY, 0, 1'b0);
    tick();

    // Reserve 1 and 4, then asynchronous reset mid-cycle
    idle(); rsv = 1'b1; rsv_regno = 4'd1;
    tick();
    idle(); rsv = 1'b1; rsv_regno = 4'd4; rd_regno = 4'd1;
    chk("r1_busy", F_RD_BUSY, 1);
    tick();
    idle(); rd_regno = 4'd4; rs_regno = 4'd1;
    chk("r4_busy", F_RD_BUSY, 1);
    chk("r1_rs_busy", F_RS_BUSY, 1);
    tick();
    idle(); rd_regno = 4'd3; rs_regno = 4'd5;
    rst = 1'b1;
    chk("async_rst_pend_any", F_PEND_ANY, 0);
    chk("async_rst_rd_data", F_RD_DATA, 0);
    chk("async_rst_rs_data", F_RS_DATA, 0);
    chk("async_rst_rd_busy", F_RD_BUSY, 0);
    tick();
    rst = 1'b0; idle(); wb = 1'b1; wb_regno = 4'd4; wb_data = 32'h77;
    chk("post_rst_wb4_err_not_yet", F_ERR, 0);
    tick();
    idle();
    chk("post_rst_wb4_err", F_ERR, 1);
    tick();

    tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
